// File: rtl/adat_tx.sv
// ADAT optical-format transmitter.
// Collects CHANNELS samples from a valid/ready stream into a pending buffer,
// assembles a 256-bit ADAT frame (sync, user nibble, 8 x 24-bit slots with
// a '1' separator ahead of every nibble) at each frame boundary, and shifts
// it out MSB first as an NRZI line, one bit per bit_en strobe.
module adat_tx #(
  parameter int CHANNELS = 8,
  parameter int SAMPLE_W = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       bit_en,
  input  logic                       timecode,
  input  logic                       midi,
  input  logic                       smux,
  input  logic signed [SAMPLE_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       bitstream_out,
  output logic                       frame_start,
  output logic                       underrun
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  // Pending sample set and its write pointer
  logic signed [SAMPLE_W-1:0] pend_mem [CHANNELS];
  logic [IDX_W-1:0]           wr_idx;
  logic                       pend_full;

  // Frame timing and serialiser
  logic [7:0]   bit_cnt;
  logic [255:0] frame_sr;

  logic         xfer;
  logic         load;
  logic         load_data;
  logic [191:0] slot_bus;
  logic [191:0] slot_sel;
  logic [255:0] frame_new;
  logic         tx_bit;

  // MSB-align a sample into a 24-bit slot; unused LSBs are zero.
  function automatic logic [23:0] align_slot(input logic signed [SAMPLE_W-1:0] s);
    logic [23:0] r;
    r = '0;
    r[23 -: SAMPLE_W] = s;
    return r;
  endfunction

  // Assemble the full 256-bit frame image, bit 255 transmitted first.
  function automatic logic [255:0] build_frame(input logic         tc,
                                               input logic         md,
                                               input logic         sm,
                                               input logic [191:0] slots);
    logic [255:0] f;
    logic [23:0]  s;
    f = '0;
    f[255:245] = 11'b100_0000_0000;
    f[244:240] = {1'b1, tc, md, sm, 1'b0};
    for (int c = 0; c < 8; c++) begin
      s = slots[c*24 +: 24];
      for (int g = 0; g < 6; g++) begin
        f[239 - 30*c - 5*g -: 5] = {1'b1, s[23 - 4*g -: 4]};
      end
    end
    return f;
  endfunction

  assign s_ready   = reset_n & ~pend_full;
  assign xfer      = s_valid & s_ready;
  assign load      = bit_en & (bit_cnt == 8'd0);
  // A set completed on the load edge itself is not yet visible here, so
  // that frame underruns and the set waits for the next boundary.
  assign load_data = load & pend_full;

  // Gather pending samples into slot order; unpopulated slots stay zero.
  always_comb begin
    slot_bus = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      slot_bus[c*24 +: 24] = align_slot(pend_mem[c]);
    end
  end

  assign slot_sel  = load_data ? slot_bus : '0;
  assign frame_new = build_frame(timecode, midi, smux, slot_sel);
  assign tx_bit    = load ? frame_new[255] : frame_sr[255];

  // Sample storage: written on every accepted transfer, never reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_mem[wr_idx] <= s_data;
    end
  end

  // Collector control: write pointer and full flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_idx    <= '0;
      pend_full <= 1'b0;
    end else begin
      if (load_data) begin
        pend_full <= 1'b0;
      end else if (xfer && (wr_idx == LAST_IDX)) begin
        pend_full <= 1'b1;
      end
      if (xfer) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
      end
    end
  end

  // Bit counter, serialiser, NRZI line and frame markers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt       <= 8'd0;
      frame_sr      <= '0;
      bitstream_out <= 1'b0;
      frame_start   <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load & ~pend_full;
      if (bit_en) begin
        bit_cnt       <= bit_cnt + 8'd1;
        bitstream_out <= bitstream_out ^ tx_bit;
        frame_sr      <= load ? {frame_new[254:0], 1'b0} : {frame_sr[254:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_adat_tx.sv
// Directed bench for adat_tx: an 8-channel/24-bit instance and a
// 2-channel/16-bit instance share clock, reset, strobe and user bits.
// Both lines are NRZI-decoded back into 256-bit frames and compared with
// frames built from hand-chosen sample values.
module tb_adat_tx;

  logic clk = 1'b0;
  logic reset_n;
  logic bit_en;
  logic timecode, midi, smux;

  logic signed [23:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic               bitstream_out, frame_start, underrun;

  logic signed [15:0] d2_data;
  logic               d2_valid;
  logic               d2_ready;
  logic               d2_bs, d2_fs, d2_ur;

  int n_checks = 0;
  int n_errors = 0;

  int en_div = 1;
  int ph     = 0;
  int cyc    = 0;
  int n_en   = 0;
  int n_xfer = 0;
  bit cont   = 0;

  logic         prev [2];
  int           idx  [2];
  logic [255:0] rx   [2];

  adat_tx #(.CHANNELS(8), .SAMPLE_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .bit_en(bit_en),
    .timecode(timecode), .midi(midi), .smux(smux),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bitstream_out(bitstream_out), .frame_start(frame_start), .underrun(underrun)
  );

  adat_tx #(.CHANNELS(2), .SAMPLE_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .bit_en(bit_en),
    .timecode(timecode), .midi(midi), .smux(smux),
    .s_data(d2_data), .s_valid(d2_valid), .s_ready(d2_ready),
    .bitstream_out(d2_bs), .frame_start(d2_fs), .underrun(d2_ur)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Reference frame built serially, bit by bit, in transmission order.
  function automatic logic [255:0] exp_frame(input logic tc, input logic md, input logic sm,
                                             input logic [23:0] sl [8]);
    logic [255:0] f;
    int p;
    f = '0;
    p = 255;
    f[p] = 1'b1; p--;
    for (int k = 0; k < 10; k++) begin f[p] = 1'b0; p--; end
    f[p] = 1'b1; p--;
    f[p] = tc;   p--;
    f[p] = md;   p--;
    f[p] = sm;   p--;
    f[p] = 1'b0; p--;
    for (int c = 0; c < 8; c++) begin
      for (int n = 5; n >= 0; n--) begin
        f[p] = 1'b1; p--;
        for (int k = 3; k >= 0; k--) begin
          f[p] = sl[c][4*n + k]; p--;
        end
      end
    end
    return f;
  endfunction

  // One clock: drive strobe, advance past the edge, decode both lines.
  task automatic step();
    logic hs, en, b;
    logic o_bs [2];
    logic o_fs [2];
    en     = (ph == 0);
    bit_en = en;
    ph     = (ph + 1 >= en_div) ? 0 : ph + 1;
    hs     = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (en) n_en++;
    if (hs) begin
      n_xfer++;
      if (cont) s_data = s_data + 24'sd1;
    end
    o_bs[0] = bitstream_out; o_bs[1] = d2_bs;
    o_fs[0] = frame_start;   o_fs[1] = d2_fs;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        prev[i] = 1'b0;
        idx[i]  = 256;
      end
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        b       = o_bs[i] ^ prev[i];
        prev[i] = o_bs[i];
        if (o_fs[i]) idx[i] = 0;
        if (idx[i] < 256) begin
          rx[i][255 - idx[i]] = b;
          idx[i]++;
        end
      end
    end
  endtask

  task automatic send(input logic [23:0] v);
    s_valid = 1'b1;
    s_data  = v;
    step();
    s_valid = 1'b0;
  endtask

  task automatic send2(input logic [15:0] v);
    d2_valid = 1'b1;
    d2_data  = v;
    step();
    d2_valid = 1'b0;
  endtask

  task automatic wait_fs(input int lim);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_start && k < lim);
    if (!frame_start) check("fs_timeout", 256'(frame_start), 256'd1);
  endtask

  task automatic collect();
    int k;
    k = 0;
    while ((idx[0] < 256 || idx[1] < 256) && k < 3000) begin
      step();
      k++;
    end
    if (idx[0] < 256 || idx[1] < 256) check("collect_timeout", 256'(idx[0]), 256'd256);
  endtask

  logic [23:0] zs  [8];
  logic [23:0] sl  [8];
  logic [23:0] sl2 [8];
  int t0, n0;

  initial begin
    reset_n = 1'b0; bit_en = 1'b0;
    timecode = 1'b0; midi = 1'b0; smux = 1'b0;
    s_data = '0; s_valid = 1'b0; d2_data = '0; d2_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin prev[i] = 1'b0; idx[i] = 256; rx[i] = '0; end
    for (int c = 0; c < 8; c++) begin zs[c] = 24'h0; sl2[c] = 24'h0; end
    sl2[0] = 24'h800000; sl2[1] = 24'h7FFF00;

    // Reset with strobe running
    repeat (3) step();
    check("rst_line",  256'(bitstream_out), 256'd0);
    check("rst_fs",    256'(frame_start),   256'd0);
    check("rst_ur",    256'(underrun),      256'd0);
    check("rst_ready", 256'(s_ready),       256'd0);
    check("rst_ready2", 256'(d2_ready),     256'd0);

    // First frame right after release, nothing collected
    reset_n = 1'b1;
    step();
    t0 = cyc;
    check("A_fs",   256'(frame_start), 256'd1);
    check("A_ur",   256'(underrun),    256'd1);
    check("A_sync", 256'(bitstream_out), 256'd1);
    repeat (10) step();
    check("A_sync_hold", 256'(bitstream_out), 256'd1);
    step();
    check("A_user_toggle", 256'(bitstream_out), 256'd0);

    // Preload both collectors for the next frame
    sl[0] = 24'h800001; sl[1] = 24'h7FFFFF; sl[2] = 24'h000000; sl[3] = 24'h000001;
    sl[4] = 24'hFFFFFF; sl[5] = 24'hA5A5A5; sl[6] = 24'h0F0F0F; sl[7] = 24'h123456;
    for (int c = 0; c < 8; c++) send(sl[c]);
    check("ready_full", 256'(s_ready), 256'd0);
    send2(16'h8000);
    send2(16'h7FFF);
    check("ready2_full", 256'(d2_ready), 256'd0);
    timecode = 1'b1; midi = 1'b0; smux = 1'b1;
    collect();
    check("A_frame",  rx[0], exp_frame(1'b0, 1'b0, 1'b0, zs));
    check("A_frame2", rx[1], exp_frame(1'b0, 1'b0, 1'b0, zs));
    check("ready_before_load", 256'(s_ready), 256'd0);

    // Frame B carries the preloaded sets; start continuous input
    wait_fs(4);
    check("period_256", 256'(cyc - t0), 256'd256);
    check("B_ur",  256'(underrun), 256'd0);
    check("B_ur2", 256'(d2_ur),    256'd0);
    check("ready_after_load", 256'(s_ready), 256'd1);
    timecode = 1'b0; midi = 1'b1; smux = 1'b1;
    cont = 1'b1; s_valid = 1'b1; s_data = 24'sh7FFFFC; n_xfer = 0;
    collect();
    check("B_frame",  rx[0], exp_frame(1'b1, 1'b0, 1'b1, sl));
    check("B_frame2", rx[1], exp_frame(1'b1, 1'b0, 1'b1, sl2));
    check("B_xfers", 256'(n_xfer), 256'd8);
    check("B_ready_low", 256'(s_ready), 256'd0);

    wait_fs(4);
    check("C_ur", 256'(underrun), 256'd0);
    check("C_load_no_xfer", 256'(n_xfer), 256'd8);
    n_xfer = 0;
    collect();
    for (int c = 0; c < 8; c++) sl[c] = 24'h7FFFFC + 24'(c);
    check("C_frame", rx[0], exp_frame(1'b0, 1'b1, 1'b1, sl));
    check("C_xfers", 256'(n_xfer), 256'd8);

    wait_fs(4);
    cont = 1'b0; s_valid = 1'b0;
    check("D_ur", 256'(underrun), 256'd0);
    // Seven samples now, the eighth exactly on the next load edge
    for (int c = 0; c < 7; c++) send({8'hC0 + 8'(c), 16'h1234});
    collect();
    for (int c = 0; c < 8; c++) sl[c] = 24'h800004 + 24'(c);
    check("D_frame", rx[0], exp_frame(1'b0, 1'b1, 1'b1, sl));
    n_xfer = 0;
    s_valid = 1'b1; s_data = 24'hC71234;
    wait_fs(1);
    s_valid = 1'b0;
    check("E_ur", 256'(underrun), 256'd1);
    check("E_late_xfer", 256'(n_xfer), 256'd1);
    collect();
    check("E_frame", rx[0], exp_frame(1'b0, 1'b1, 1'b1, zs));
    wait_fs(4);
    check("F_ur", 256'(underrun), 256'd0);
    collect();
    for (int c = 0; c < 8; c++) sl[c] = {8'hC0 + 8'(c), 16'h1234};
    check("F_frame", rx[0], exp_frame(1'b0, 1'b1, 1'b1, sl));

    // Strobe every third clock, reset pulsed mid-frame at bit_cnt 100
    timecode = 1'b0; midi = 1'b0; smux = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; en_div = 3; ph = 0;
    step();
    check("R0_fs", 256'(frame_start), 256'd1);
    n0 = n_en;
    for (int c = 0; c < 3; c++) send(24'h111111 * 24'(c + 1));
    while (n_en - n0 + 1 < 100) step();
    reset_n = 1'b0;
    step();
    check("R0_line_cleared", 256'(bitstream_out), 256'd0);
    check("R0_fs_cleared",   256'(frame_start),   256'd0);
    step();
    reset_n = 1'b1; ph = 0;
    step();
    t0 = cyc;
    check("R1_fs",   256'(frame_start),   256'd1);
    check("R1_ur",   256'(underrun),      256'd1);
    check("R1_sync", 256'(bitstream_out), 256'd1);
    for (int c = 0; c < 8; c++) begin
      sl[c] = {8'hE0 + 8'(c), 16'h5A5A};
      send(sl[c]);
    end
    collect();
    check("R1_frame", rx[0], exp_frame(1'b0, 1'b0, 1'b0, zs));
    wait_fs(8);
    check("period_768", 256'(cyc - t0), 256'd768);
    check("R2_ur", 256'(underrun), 256'd0);
    collect();
    check("R2_frame", rx[0], exp_frame(1'b0, 1'b0, 1'b0, sl));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
